// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//   APB4 initiator. Takes one command at a time from a valid/ready port,
//   runs the SETUP / ACCESS phases on the APB bus and returns read data and
//   the slave error flag on a registered valid/ready response port. Only one
//   transfer is ever outstanding.
//
// Optional feature (compile-time macro):
//   APB_CMD_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that sees
//   PREADY=0 for TIMEOUT_CYCLES cycles is aborted with rsp_err=1 and
//   rsp_rdata=0. When undefined, ACCESS waits for PREADY indefinitely.
//
// Parameters:
//   PADDR_SIZE      APB address width
//   PDATA_SIZE      APB data width (multiple of 8), PSTRB is PDATA_SIZE/8 wide
//   TIMEOUT_CYCLES  ACCESS wait limit (timeout build only)
//
// Ports:
//   PCLK, PRESET         clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot  command payload
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   response payload (rdata is 0 for writes and aborts)
//   PSEL, PENABLE, PPROT, PADDR, PWRITE, PSTRB, PWDATA  APB master outputs
//   PRDATA, PREADY, PSLVERR                             APB slave returns
// -----------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int PADDR_SIZE     = 16,
  parameter int PDATA_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_SIZE = PDATA_SIZE / 8;

  // Reject parameter sets the datapath cannot represent.
  if (((PDATA_SIZE % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("apb_cmd_master: PDATA_SIZE must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;

  logic                   cmd_ready_r;
  logic                   rsp_valid_r;
  logic                   psel_r;
  logic                   penable_r;
  logic [2:0]             pprot_r;
  logic [PADDR_SIZE-1:0]  paddr_r;
  logic                   pwrite_r;
  logic [STRB_SIZE-1:0]   pstrb_r;
  logic [PDATA_SIZE-1:0]  pwdata_r;
  logic [PDATA_SIZE-1:0]  rsp_rdata_r;
  logic                   rsp_err_r;

  logic                   accept_s;
  logic                   xfer_done_s;
  logic                   abort_s;

  // cmd_ready_r is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept_s    = cmd_ready_r & cmd_valid;
  // In ACCESS both PSEL and PENABLE are high, so PREADY alone completes.
  assign xfer_done_s = (state_r == ST_ACCESS) & PREADY;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_r;

  // The abort fires on the ACCESS cycle whose increment would reach the
  // limit; PREADY on that same cycle wins via xfer_done_s.
  assign abort_s = (state_r == ST_ACCESS) & ~PREADY &
                   (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // ACCESS wait counter: cleared while in SETUP so it starts at 0 on ACCESS entry.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_SETUP) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !PREADY) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_next_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (xfer_done_s || abort_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register plus handshake/phase flags decoded from the next state,
  // so every control output comes straight from a flop.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= (state_next_s == ST_IDLE);
      psel_r      <= (state_next_s == ST_SETUP) || (state_next_s == ST_ACCESS);
      penable_r   <= (state_next_s == ST_ACCESS);
      rsp_valid_r <= (state_next_s == ST_RESP);
    end
  end

  // Request payload: captured at accept and held until the next accept.
  // Strobes and write data are zeroed for reads.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_r  <= {PADDR_SIZE{1'b0}};
      pwrite_r <= 1'b0;
      pprot_r  <= 3'b000;
      pstrb_r  <= {STRB_SIZE{1'b0}};
      pwdata_r <= {PDATA_SIZE{1'b0}};
    end else if (accept_s) begin
      paddr_r  <= cmd_addr;
      pwrite_r <= cmd_write;
      pprot_r  <= cmd_prot;
      pstrb_r  <= cmd_write ? cmd_strb  : {STRB_SIZE{1'b0}};
      pwdata_r <= cmd_write ? cmd_wdata : {PDATA_SIZE{1'b0}};
    end else begin
      paddr_r  <= paddr_r;
      pwrite_r <= pwrite_r;
      pprot_r  <= pprot_r;
      pstrb_r  <= pstrb_r;
      pwdata_r <= pwdata_r;
    end
  end

  // Response payload: captured on completion or abort, held through RESP.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_rdata_r <= {PDATA_SIZE{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (xfer_done_s) begin
      rsp_rdata_r <= pwrite_r ? {PDATA_SIZE{1'b0}} : PRDATA;
      rsp_err_r   <= PSLVERR;
    end else if (abort_s) begin
      rsp_rdata_r <= {PDATA_SIZE{1'b0}};
      rsp_err_r   <= 1'b1;
    end else begin
      rsp_rdata_r <= rsp_rdata_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign PSEL      = psel_r;
  assign PENABLE   = penable_r;
  assign PPROT     = pprot_r;
  assign PADDR     = paddr_r;
  assign PWRITE    = pwrite_r;
  assign PSTRB     = pstrb_r;
  assign PWDATA    = pwdata_r;

endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
//   Directed plus randomized bench for apb_cmd_master. The bench plays the APB
//   slave and the command/response agents; expected bus and response values
//   come from the transaction description (address, data, wait count, error).
//   Build with APB_CMD_MASTER_TIMEOUT_EN to exercise the timeout abort path.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic [2:0]    PPROT;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  apb_cmd_master #(
    .PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=run still active expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transfer. waits = ACCESS cycles with PREADY=0 before the
  // completing cycle; rdelay = RESP cycles with rsp_ready=0.
  task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                         input bit err, input logic [DW-1:0] rd, input int rdelay);
    logic [SW-1:0] e_strb;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd;
    e_strb = wr ? st : '0;
    e_wd   = wr ? wd : '0;
    e_rd   = wr ? '0 : rd;
    // accept cycle N
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    cmd_strb = st; cmd_prot = pr; rsp_ready = 1'b0;
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    tick();
    // SETUP at N+1; scramble command inputs and drive junk on the slave side
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
    cmd_wdata = $urandom; cmd_strb = SW'($urandom); cmd_prot = 3'($urandom);
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("setup_paddr", 32'(PADDR), 32'(a));
    chk("setup_pwrite", 32'(PWRITE), 32'(wr));
    chk("setup_pprot", 32'(PPROT), 32'(pr));
    chk("setup_pstrb", 32'(PSTRB), 32'(e_strb));
    chk("setup_pwdata", PWDATA, e_wd);
    tick();
    // ACCESS from N+2
    for (int i = 0; i <= waits; i++) begin
      chk("access_psel", 32'(PSEL), 32'd1);
      chk("access_penable", 32'(PENABLE), 32'd1);
      chk("access_paddr", 32'(PADDR), 32'(a));
      chk("access_pwdata", PWDATA, e_wd);
      chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
      PREADY  = (i == waits);
      PRDATA  = (i == waits) ? rd : $urandom;
      PSLVERR = (i == waits) ? err : 1'($urandom);
      rsp_ready = (i == waits) && (rdelay == 0);
      tick();
    end
    // RESP
    PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
    for (int j = 0; j <= rdelay; j++) begin
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_rdata", rsp_rdata, e_rd);
      chk("resp_err", 32'(rsp_err), 32'(err));
      chk("resp_psel", 32'(PSEL), 32'd0);
      chk("resp_penable", 32'(PENABLE), 32'd0);
      chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      if (j < rdelay) begin
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
      end else begin
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      tick();
    end
    rsp_ready = 1'b0;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_psel", 32'(PSEL), 32'd0);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_pprot", 32'(PPROT), 32'd0);
    chk("rst_pstrb", 32'(PSTRB), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    tick();
    tick();
    PRESET = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // write with zero wait states, minimum latency
    do_xfer(1'b1, 16'h1234, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0BAD_F00D, 0);
    // read with 3 wait states
    do_xfer(1'b0, 16'h0040, 32'h1111_2222, 4'hA, 3'd5, 3, 1'b0, 32'hA5A5_0001, 1);
    // read with slave error, then a clean read
    do_xfer(1'b0, 16'h0080, 32'h0, 4'h0, 3'd2, 1, 1'b1, 32'h1357_9BDF, 0);
    do_xfer(1'b0, 16'h0084, 32'h0, 4'h0, 3'd2, 0, 1'b0, 32'h2468_ACE0, 0);
    // response back-pressure for 5 cycles with a pending command
    do_xfer(1'b1, 16'h0100, 32'hCAFE_0123, 4'h3, 3'd7, 2, 1'b1, 32'h5555_AAAA, 5);
    // 7 wait states then PREADY on the 8th ACCESS cycle
    do_xfer(1'b0, 16'h0200, 32'h0, 4'h0, 3'd1, 7, 1'b0, 32'h7777_8888, 0);

    // reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0077;
    tick();
    cmd_valid = 1'b0;
    tick();
    PREADY = 1'b0;
    chk("pre_rst_penable", 32'(PENABLE), 32'd1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("async_rst_psel", 32'(PSEL), 32'd0);
    chk("async_rst_penable", 32'(PENABLE), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    PRESET = 1'b0;
    tick();
    chk("rerst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rerst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rerst_no_rsp", 32'(rsp_valid), 32'd0);

    // stuck slave
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0ABC;
    tick();
    cmd_valid = 1'b0;
    tick();
    PREADY = 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("to_access_penable", 32'(PENABLE), 32'd1);
      chk("to_access_rsp_valid", 32'(rsp_valid), 32'd0);
      PRDATA = $urandom;
      tick();
    end
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_psel", 32'(PSEL), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`else
    repeat (1000) tick();
    chk("stuck_psel", 32'(PSEL), 32'd1);
    chk("stuck_penable", 32'(PENABLE), 32'd1);
    chk("stuck_rsp_valid", 32'(rsp_valid), 32'd0);
    PREADY = 1'b1; PRDATA = 32'h0F0F_1234; PSLVERR = 1'b0;
    tick();
    PREADY = 1'b0;
    chk("stuck_done_valid", 32'(rsp_valid), 32'd1);
    chk("stuck_done_rdata", rsp_rdata, 32'h0F0F_1234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif
    chk("after_stuck_cmd_ready", 32'(cmd_ready), 32'd1);

    // randomized transfers
    for (int k = 0; k < 25; k++) begin
      do_xfer(1'($urandom), AW'($urandom), $urandom, SW'($urandom), 3'($urandom),
              int'($urandom_range(0, 5)), 1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
